// File: rtl/conv3x3_mac_pkg.sv
// Shared constants and width helpers for the 3x3 convolution MAC and its stages.
package conv3x3_mac_pkg;

  // Default fixed-point format: Q8.4, 12-bit words.
  localparam int CONV_INT_BITS  = 8;
  localparam int CONV_FRAC_BITS = 4;
  localparam int TAPS           = 9;

  // Word width from integer and fractional bit counts.
  function automatic int word_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  // Full-precision product width of two W-bit signed words.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // Nine 2W-bit products summed: 4 guard bits make overflow impossible.
  function automatic int sum_width(input int w);
    return 2 * w + 4;
  endfunction

  // Half an LSB of the output format, added before truncating the fraction.
  function automatic int round_const(input int frac_bits);
    return 32'sd1 <<< (frac_bits - 1);
  endfunction

  // Largest positive W-bit signed value.
  function automatic int sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Most negative W-bit signed value.
  function automatic int sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  localparam int CONV_W      = word_width(CONV_INT_BITS, CONV_FRAC_BITS);
  localparam int CONV_PROD_W = prod_width(CONV_W);
  localparam int CONV_SUM_W  = sum_width(CONV_W);
  localparam int CONV_RND    = round_const(CONV_FRAC_BITS);
  localparam int CONV_SATMAX = sat_max(CONV_W);
  localparam int CONV_SATMIN = sat_min(CONV_W);

endpackage

// File: rtl/conv3x3_mac_sat_round.sv
// Output stage arithmetic: round to nearest (half up), drop the fraction,
// saturate to the W-bit signed range and optionally clamp negatives to zero.
module sat_round
  import conv3x3_mac_pkg::*;
#(
  parameter int W       = CONV_W,
  parameter int FRAC    = CONV_FRAC_BITS,
  parameter int RELU_EN = 1
) (
  input  logic signed [sum_width(W)-1:0] sum,
  output logic        [W-1:0]            result
);

  localparam int SUM_W = sum_width(W);
  localparam logic signed [SUM_W-1:0] RND    = SUM_W'(round_const(FRAC));
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(W));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(W));

  logic signed [SUM_W-1:0] rounded_s;
  logic signed [SUM_W-1:0] shifted_s;
  logic        [W-1:0]     sat_s;

  // Round, arithmetic shift, clamp to range, then ReLU.
  always_comb begin
    rounded_s = sum + RND;
    shifted_s = rounded_s >>> FRAC;
    if (shifted_s > SAT_HI) begin
      sat_s = SAT_HI[W-1:0];
    end else if (shifted_s < SAT_LO) begin
      sat_s = SAT_LO[W-1:0];
    end else begin
      sat_s = shifted_s[W-1:0];
    end
    if ((RELU_EN != 32'sd0) && sat_s[W-1]) begin
      result = '0;
    end else begin
      result = sat_s;
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: serial weight load into a staging bank, commit to an
// active bank, then a 3-stage multiply / sum / round-saturate pipeline.
module conv3x3_mac
  import conv3x3_mac_pkg::*;
#(
  parameter int INTEGER_BITS     = CONV_INT_BITS,
  parameter int FIXED_POINT_BITS = CONV_FRAC_BITS,
  parameter int RELU_EN          = 1,
  parameter int LINE_PIXELS      = 512
) (
  input  logic                                                    i_clk,
  input  logic                                                    i_rst,
  input  logic [9*word_width(INTEGER_BITS, FIXED_POINT_BITS)-1:0] i_pixel_data,
  input  logic                                                    i_pixel_data_valid,
  input  logic [word_width(INTEGER_BITS, FIXED_POINT_BITS)-1:0]   i_wt_data,
  input  logic                                                    i_wt_valid,
  output logic                                                    o_wt_ready,
  output logic [word_width(INTEGER_BITS, FIXED_POINT_BITS)-1:0]   o_conv_data,
  output logic                                                    o_conv_data_valid,
  output logic                                                    o_line_done
);

  localparam int W      = word_width(INTEGER_BITS, FIXED_POINT_BITS);
  localparam int PROD_W = prod_width(W);
  localparam int SUM_W  = sum_width(W);
  localparam int CNT_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_PIXELS - 1);

  logic        [3:0]       wt_cnt_r;
  logic signed [W-1:0]     stage_r  [TAPS];
  logic signed [W-1:0]     active_r [TAPS];
  logic                    commit_r;
  logic                    wt_ready_r;
  logic                    accept_s;
  logic signed [PROD_W-1:0] prod_r  [TAPS];
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] sum_r;
  logic        [2:0]       vld_r;
  logic        [W-1:0]     rnd_s;
  logic        [W-1:0]     conv_r;
  logic        [CNT_W-1:0] out_cnt_r;
  logic                    line_done_r;

  // A window enters the pipe only once a full kernel has been committed.
  assign accept_s = i_pixel_data_valid & wt_ready_r;

  // Serial weight staging; the write into slot 8 arms a commit on the next edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wt_cnt_r   <= 4'd0;
      commit_r   <= 1'b0;
      wt_ready_r <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        stage_r[k]  <= '0;
        active_r[k] <= '0;
      end
    end else begin
      commit_r <= 1'b0;
      if (i_wt_valid) begin
        stage_r[wt_cnt_r] <= i_wt_data;
        if (wt_cnt_r == 4'd8) begin
          wt_cnt_r <= 4'd0;
          commit_r <= 1'b1;
        end else begin
          wt_cnt_r <= wt_cnt_r + 4'd1;
        end
      end
      // Windows accepted on this same edge still see the old active bank.
      if (commit_r) begin
        active_r   <= stage_r;
        wt_ready_r <= 1'b1;
      end
    end
  end

  // Stage 1: nine full-width signed products; valid pipe shifts alongside.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_r <= 3'b000;
      for (int k = 0; k < TAPS; k++) begin
        prod_r[k] <= '0;
      end
    end else begin
      vld_r <= {vld_r[1:0], accept_s};
      if (accept_s) begin
        for (int k = 0; k < TAPS; k++) begin
          prod_r[k] <= PROD_W'($signed(i_pixel_data[W*k +: W])) * PROD_W'(active_r[k]);
        end
      end
    end
  end

  // Adder tree over the sign-extended products.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_s = sum_s + SUM_W'(prod_r[k]);
    end
  end

  // Stage 2: register the product sum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_r <= '0;
    end else begin
      sum_r <= sum_s;
    end
  end

  sat_round #(
    .W       (W),
    .FRAC    (FIXED_POINT_BITS),
    .RELU_EN (RELU_EN)
  ) u_sat_round (
    .sum    (sum_r),
    .result (rnd_s)
  );

  // Stage 3: capture the rounded result (held between valid outputs) and
  // count outputs per line, pulsing line_done with the last one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conv_r      <= '0;
      out_cnt_r   <= '0;
      line_done_r <= 1'b0;
    end else begin
      line_done_r <= 1'b0;
      if (vld_r[1]) begin
        conv_r <= rnd_s;
        if (out_cnt_r == LAST_CNT) begin
          out_cnt_r   <= '0;
          line_done_r <= 1'b1;
        end else begin
          out_cnt_r <= out_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign o_wt_ready        = wt_ready_r;
  assign o_conv_data       = conv_r;
  assign o_conv_data_valid = vld_r[2];
  assign o_line_done       = line_done_r;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed self-checking bench for conv3x3_mac, with one instance using ReLU
// and one without, sharing the same stimulus.
module tb_conv3x3_mac;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [9*W-1:0] pix;
  logic           pix_vld;
  logic [W-1:0]   wt;
  logic           wt_vld;

  logic           rdy1, vld1, ld1;
  logic [W-1:0]   data1;
  logic           rdy0, vld0, ld0;
  logic [W-1:0]   data0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] out_q[$];
  logic         ld_q[$];
  int           stray_ld = 0;

  conv3x3_mac #(.RELU_EN(1)) u_dut_relu (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(pix_vld),
    .i_wt_data(wt), .i_wt_valid(wt_vld), .o_wt_ready(rdy1),
    .o_conv_data(data1), .o_conv_data_valid(vld1), .o_line_done(ld1)
  );

  conv3x3_mac #(.RELU_EN(0)) u_dut_lin (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(pix_vld),
    .i_wt_data(wt), .i_wt_valid(wt_vld), .o_wt_ready(rdy0),
    .o_conv_data(data0), .o_conv_data_valid(vld0), .o_line_done(ld0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*W-1:0] fill(input logic [W-1:0] v);
    logic [9*W-1:0] r;
    for (int k = 0; k < 9; k++) r[W*k +: W] = v;
    return r;
  endfunction

  // Record every valid output of the ReLU instance.
  always @(negedge clk) begin
    if (vld1) begin
      out_q.push_back(data1);
      ld_q.push_back(ld1);
    end else if (ld1) begin
      stray_ld++;
    end
  end

  task automatic load_weights(input logic [W-1:0] w, input logic chk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wt     = w;
      wt_vld = 1'b1;
    end
    @(negedge clk);
    wt_vld = 1'b0;
    if (chk) check_eq("wt_ready_before_commit", 32'(rdy1), 32'd0);
    @(negedge clk);
    if (chk) check_eq("wt_ready_after_commit", 32'(rdy1), 32'd1);
  endtask

  task automatic single_window(input string tag, input logic [W-1:0] p,
                               input logic [W-1:0] e1, input logic [W-1:0] e0);
    @(negedge clk);
    pix     = fill(p);
    pix_vld = 1'b1;
    @(negedge clk);
    pix_vld = 1'b0;
    check_eq({tag, "_vld_c1"}, 32'(vld1), 32'd0);
    @(negedge clk);
    check_eq({tag, "_vld_c2"}, 32'(vld1), 32'd0);
    @(negedge clk);
    check_eq({tag, "_vld_c3"}, 32'(vld1), 32'd1);
    check_eq({tag, "_data_relu"}, 32'(data1), 32'(e1));
    check_eq({tag, "_vld_lin"}, 32'(vld0), 32'd1);
    check_eq({tag, "_data_lin"}, 32'(data0), 32'(e0));
    @(negedge clk);
    check_eq({tag, "_vld_c4"}, 32'(vld1), 32'd0);
    check_eq({tag, "_hold"}, 32'(data1), 32'(e1));
  endtask

  initial begin
    int ld_n, first_ld, last_ld, bad_data;
    rst     = 1'b1;
    pix     = '0;
    pix_vld = 1'b0;
    wt      = '0;
    wt_vld  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", 32'(data1), 32'd0);
    check_eq("rst_valid", 32'(vld1), 32'd0);
    check_eq("rst_line_done", 32'(ld1), 32'd0);
    check_eq("rst_wt_ready", 32'(rdy1), 32'd0);
    rst = 1'b0;

    // Window with no kernel loaded is dropped.
    out_q.delete();
    @(negedge clk);
    pix     = fill(12'h010);
    pix_vld = 1'b1;
    @(negedge clk);
    pix_vld = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("drop_unloaded", 32'(out_q.size()), 32'd0);

    load_weights(12'h010, 1'b1);
    single_window("unit", 12'h010, 12'h090, 12'h090);

    // Reset with two windows in flight.
    @(negedge clk);
    pix_vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pix_vld = 1'b0;
    rst     = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(vld1), 32'd0);
    check_eq("midrst_data", 32'(data1), 32'd0);
    check_eq("midrst_wt_ready", 32'(rdy1), 32'd0);
    out_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("midrst_no_output", 32'(out_q.size()), 32'd0);
    check_eq("midrst_wt_ready_low", 32'(rdy1), 32'd0);
    @(negedge clk);
    pix_vld = 1'b1;
    @(negedge clk);
    pix_vld = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midrst_dropped", 32'(out_q.size()), 32'd0);

    // Two full lines of back-to-back windows.
    load_weights(12'h010, 1'b0);
    out_q.delete();
    ld_q.delete();
    stray_ld = 0;
    pix = fill(12'h010);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pix_vld = 1'b1;
    end
    @(negedge clk);
    pix_vld = 1'b0;
    for (int t = 0; t < 20 && out_q.size() < 1024; t++) @(negedge clk);
    check_eq("line_count", 32'(out_q.size()), 32'd1024);
    ld_n = 0; first_ld = -1; last_ld = -1; bad_data = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] !== 12'h090) bad_data++;
      if (ld_q[i] === 1'b1) begin
        ld_n++;
        if (first_ld < 0) first_ld = i;
        last_ld = i;
      end
    end
    check_eq("line_pulses", 32'(ld_n), 32'd2);
    check_eq("line_first", 32'(first_ld), 32'd511);
    check_eq("line_second", 32'(last_ld), 32'd1023);
    check_eq("line_data_errs", 32'(bad_data), 32'd0);
    check_eq("line_stray", 32'(stray_ld), 32'd0);

    // Bank switch while streaming: weights written on windows 3..11,
    // commit on window 12's edge, new bank from window 13.
    out_q.delete();
    pix = fill(12'h010);
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          pix_vld = 1'b1;
        end
        @(negedge clk);
        pix_vld = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          wt     = 12'h020;
          wt_vld = 1'b1;
        end
        @(negedge clk);
        wt_vld = 1'b0;
      end
    join
    for (int t = 0; t < 20 && out_q.size() < 20; t++) @(negedge clk);
    check_eq("bank_sw_count", 32'(out_q.size()), 32'd20);
    for (int i = 0; i < out_q.size() && i < 20; i++) begin
      check_eq($sformatf("bank_sw[%0d]", i), 32'(out_q[i]),
               (i < 13) ? 32'h090 : 32'h120);
    end

    // Saturation, ReLU and rounding.
    load_weights(12'h7FF, 1'b0);
    single_window("sat_pos", 12'h7FF, 12'h7FF, 12'h7FF);
    load_weights(12'h800, 1'b0);
    single_window("sat_neg", 12'h7FF, 12'h000, 12'h800);
    single_window("sat_negneg", 12'h800, 12'h7FF, 12'h7FF);
    load_weights(12'h001, 1'b0);
    single_window("round_pos", 12'h008, 12'h005, 12'h005);
    single_window("round_neg", 12'hFF8, 12'h000, 12'hFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 Parameter INTEGER_BITS, default 8, integer bits of the signed fixed-point pixel/weight format.
REQ-002 Parameter FIXED_POINT_BITS, default 4, fractional bits; word width W = INTEGER_BITS+FIXED_POINT_BITS (12).
REQ-003 Parameter RELU_EN, default 1, when 1 negative results are clamped to zero.
REQ-004 Parameter LINE_PIXELS, default 512, valid outputs per line for the line-done pulse.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous and active-high.
REQ-007 i_pixel_data  input  9*W  3x3 window; element k = bits [W*k+W-1 : W*k], k=0..8; k=0..2 oldest row, k=6..8 newest row.
REQ-008 i_pixel_data_valid  input  1  window qualifier, one window per cycle when high.
REQ-009 i_wt_data  input  W  serial kernel weight, signed fixed point.
REQ-010 i_wt_valid  input  1  weight write strobe.
REQ-011 o_wt_ready  output  1  high when a complete kernel is committed.
REQ-012 o_conv_data  output  W  convolution result, signed fixed point.
REQ-013 o_conv_data_valid  output  1  result qualifier.
REQ-014 o_line_done  output  1  one-cycle pulse on the LINE_PIXELS-th valid output of a line.

Function
REQ-015 All pixel and weight words SHALL be two's-complement Q(INTEGER_BITS).(FIXED_POINT_BITS).
REQ-016 Weight loading: each i_wt_valid cycle SHALL write i_wt_data to staging slot wt_cnt, then increment wt_cnt 0..8 and wrap to 0 after 8.
REQ-017 On the write into slot 8, the 9 staged weights SHALL be copied to the active bank on the following edge, and o_wt_ready SHALL go high and stay high until reset.
REQ-018 Active-bank commit SHALL take effect only for windows accepted after the commit edge; windows already in the pipeline SHALL complete with the previous bank.
REQ-019 Windows presented while o_wt_ready is low SHALL be dropped, with no o_conv_data_valid generated for them.
REQ-020 Stage 1 SHALL register 9 products p_k = pixel_k * weight_k at full 2W signed width.
REQ-021 Stage 2 SHALL register the sum of the 9 products at 2W+4 bits signed, with no overflow possible.
REQ-022 Stage 3 SHALL round by adding 2^(FIXED_POINT_BITS-1), arithmetic-shift right FIXED_POINT_BITS, and saturate to W-bit signed range [-2^(W-1), 2^(W-1)-1].
REQ-023 Stage 3 SHALL then apply ReLU if RELU_EN=1.
REQ-024 Latency SHALL be exactly 3 cycles from an accepted window to o_conv_data_valid, with throughput of one window per cycle and no backpressure.
REQ-025 The valid flag SHALL propagate through a 3-bit shift register alongside the data; bubbles SHALL be preserved.
REQ-026 o_conv_data SHALL hold its last value while o_conv_data_valid is low.
REQ-027 An output counter SHALL count valid outputs 0..LINE_PIXELS-1.
REQ-028 When the count reaches LINE_PIXELS-1 with valid high, o_line_done SHALL pulse coincident with that output and the counter SHALL wrap to 0.
REQ-029 Simultaneous i_wt_valid and i_pixel_data_valid SHALL both be honoured; the window uses the bank active at its acceptance edge.

Reset
REQ-030 While i_rst is high, o_conv_data=0, o_conv_data_valid=0, o_line_done=0 and o_wt_ready=0.
REQ-031 While i_rst is high, wt_cnt=0, the output counter=0, the valid pipe=0, and both weight banks=0.
REQ-032 Reset asserted mid-operation SHALL flush in-flight windows immediately; no valid output SHALL appear for pre-reset windows after release.

Structure
REQ-033 Shared package SHALL hold the W-derived width constants, the rounding constant, and the saturation min/max constants for reuse by sibling stages.
REQ-034 One sub-module, sat_round, SHALL implement the REQ-022/REQ-023 round, saturate and ReLU step as combinational logic; stage registers SHALL stay in conv3x3_mac.

Verification
REQ-035 Load nine weights of 0x010 (1.0) and drive window pixels all 0x010 -> o_conv_data=0x090 (9.0) exactly 3 cycles later, valid one cycle.
REQ-036 Load weights 0x7FF and pixels 0x7FF -> 0x7FF saturated; with weights 0x800 (-128.0), RELU_EN=0 -> 0x800; RELU_EN=1 -> 0x000.
REQ-037 Drive 512 back-to-back windows after load -> o_line_done high only with output 512, and the counter restarts for the next 512.
REQ-038 Stream windows with bank A (all 1.0) while loading bank B (all 2.0, 0x020) -> outputs switch from 0x090 to 0x120 (pixels 0x010) exactly at the first window after the commit edge.
REQ-039 Assert i_rst with 2 windows in flight -> no valid output after release; o_wt_ready=0, and windows are dropped until 9 new weights are loaded.
